// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals shared by the two-port ALU arbiter.
// ReqValid/ReqReady and RspValid/RspReady are strict valid/ready pairs: a transfer happens on
// the rising edge where both are high, valid never waits on ready, and payload is sampled only then.
interface alu_arbiter_if #(
    parameter int W = 8
);
    logic [1:0]     ReqValid;
    logic [1:0]     ReqReady;
    logic [2*W-1:0] ReqA;
    logic [2*W-1:0] ReqB;
    logic [5:0]     ReqOP;
    logic [5:0]     ReqCond;
    logic [1:0]     ReqSC;
    logic [1:0]     ReqLock;
    logic [1:0]     RspValid;
    logic [1:0]     RspReady;
    logic [2*W-1:0] RspOut;
    logic [9:0]     RspFlags;
    logic [W-1:0]   AluInputA;
    logic [W-1:0]   AluInputB;
    logic [2:0]     AluOP;
    logic [2:0]     AluCondition;
    logic           AluSC_in;
    logic [W-1:0]   AluOut;
    logic           AluZero;
    logic           AluParity;
    logic           AluOdd;
    logic           AluSC_out;
    logic           AluCondFlag;

    modport slave (
        input  ReqValid, ReqA, ReqB, ReqOP, ReqCond, ReqSC, ReqLock, RspReady,
        input  AluOut, AluZero, AluParity, AluOdd, AluSC_out, AluCondFlag,
        output ReqReady, RspValid, RspOut, RspFlags,
        output AluInputA, AluInputB, AluOP, AluCondition, AluSC_in
    );

    modport master (
        output ReqValid, ReqA, ReqB, ReqOP, ReqCond, ReqSC, ReqLock, RspReady,
        output AluOut, AluZero, AluParity, AluOdd, AluSC_out, AluCondFlag,
        input  ReqReady, RspValid, RspOut, RspFlags,
        input  AluInputA, AluInputB, AluOP, AluCondition, AluSC_in
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with
// per-port registered response slots and a watchdog-bounded grant lock.
module alu_arbiter #(
    parameter int W        = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    alu_arbiter_if.slave bus,
    output logic [1:0]   o_dbg_state
);
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    // o_dbg_state encoding: 0 = idle, 1 = locked to port 0, 2 = locked to port 1
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_rr_last;
    logic [CW-1:0]  r_lock_cnt;
    logic [1:0]     r_rsp_valid;
    logic [2*W-1:0] r_rsp_out;
    logic [9:0]     r_rsp_flags;

    logic [1:0]     w_free;
    logic [1:0]     w_elig;
    logic [1:0]     w_grant;
    logic           w_sel;
    logic           w_lock_req;

    always_comb begin
        w_free  = ~r_rsp_valid | bus.RspReady;
        w_elig  = bus.ReqValid & w_free;
        w_grant = 2'b00;
        if (Reset_n) begin
            case (r_state)
                S_IDLE: begin
                    // On a tie the port that was not served last wins.
                    if (&w_elig) w_grant = r_rr_last ? 2'b01 : 2'b10;
                    else         w_grant = w_elig;
                end
                S_LOCK0: w_grant = {1'b0, w_elig[0]};
                S_LOCK1: w_grant = {w_elig[1], 1'b0};
                default: w_grant = 2'b00;
            endcase
        end
        w_sel      = w_grant[1];
        w_lock_req = w_sel ? bus.ReqLock[1] : bus.ReqLock[0];
    end

    always_comb begin
        bus.AluInputA    = '0;
        bus.AluInputB    = '0;
        bus.AluOP        = 3'b000;
        bus.AluCondition = 3'b111;
        bus.AluSC_in     = 1'b0;
        if (|w_grant) begin
            bus.AluInputA    = w_sel ? bus.ReqA[2*W-1:W] : bus.ReqA[W-1:0];
            bus.AluInputB    = w_sel ? bus.ReqB[2*W-1:W] : bus.ReqB[W-1:0];
            bus.AluOP        = w_sel ? bus.ReqOP[5:3]    : bus.ReqOP[2:0];
            bus.AluCondition = w_sel ? bus.ReqCond[5:3]  : bus.ReqCond[2:0];
            bus.AluSC_in     = w_sel ? bus.ReqSC[1]      : bus.ReqSC[0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_rr_last   <= 1'b1;
            r_lock_cnt  <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i]         <= 1'b1;
                    r_rsp_out[i*W +: W]    <= bus.AluOut;
                    r_rsp_flags[i*5 +: 5]  <= {bus.AluCondFlag, bus.AluSC_out, bus.AluOdd,
                                               bus.AluParity, bus.AluZero};
                end else if (bus.RspReady[i] && r_rsp_valid[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end

            if (|w_grant) begin
                r_rr_last <= w_sel;
                case (r_state)
                    S_IDLE: begin
                        if (w_lock_req && (LOCK_MAX > 1)) begin
                            r_state    <= w_sel ? S_LOCK1 : S_LOCK0;
                            r_lock_cnt <= CW'(1);
                        end
                    end
                    S_LOCK0, S_LOCK1: begin
                        // Reaching CNT_LAST is the watchdog: the lock is dropped regardless of ReqLock.
                        if (w_lock_req && (r_lock_cnt < CNT_LAST)) begin
                            r_lock_cnt <= r_lock_cnt + CW'(1);
                        end else begin
                            r_state    <= S_IDLE;
                            r_lock_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_lock_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.ReqReady = w_grant;
    assign bus.RspValid = r_rsp_valid;
    assign bus.RspOut   = r_rsp_out;
    assign bus.RspFlags = r_rsp_flags;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand sequences for
// reset/contention/backpressure/lock, and randomized traffic against a transaction model.
module tb_alu_arbiter;
    localparam int W        = 8;
    localparam int LOCK_MAX = 4;

    // ---------------- clock / reset ----------------
    logic Clk;
    logic Reset_n;
    logic [1:0] dbg_state;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W), .LOCK_MAX(LOCK_MAX)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- ALU stand-in ----------------
    // Result word layout: {cond_flag, sc_out, odd, parity, zero, out[7:0]}
    function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic [2:0] cond,
                                           input logic sc);
        logic [8:0] t;
        logic [7:0] o;
        logic       f;
        case (op)
            3'd0:    t = {1'b0, a} + {1'b0, b} + {8'd0, sc};
            3'd1:    t = {1'b0, a} - {1'b0, b} - {8'd0, sc};
            3'd2:    t = {1'b0, a & b};
            3'd3:    t = {1'b0, a | b};
            3'd4:    t = {1'b0, a ^ b};
            3'd5:    t = {a[7], a[6:0], sc};
            3'd6:    t = {a[0], sc, a[7:1]};
            default: t = {1'b0, a};
        endcase
        case (cond)
            3'd0:    f = (a == b);
            3'd1:    f = (a != b);
            3'd2:    f = (a > b);
            3'd3:    f = (a < b);
            3'd4:    f = (a >= b);
            3'd5:    f = (a <= b);
            3'd6:    f = 1'b1;
            default: f = 1'b0;
        endcase
        o = t[7:0];
        return {f, t[8], o[0], ^o, (o == 8'd0), o};
    endfunction

    logic [12:0] alu_r;
    always_comb begin
        alu_r = alu_fn(bus.AluInputA, bus.AluInputB, bus.AluOP, bus.AluCondition, bus.AluSC_in);
        {bus.AluCondFlag, bus.AluSC_out, bus.AluOdd, bus.AluParity, bus.AluZero, bus.AluOut} = alu_r;
    end

    // ---------------- scoreboard / model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];
    logic [1:0]  m_valid;
    logic        m_rr_last;
    int          m_lock_owner;
    int          m_lock_run;
    logic [1:0]  obs_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_grant();
        logic [1:0] elig;
        for (int i = 0; i < 2; i++)
            elig[i] = bus.ReqValid[i] && (!m_valid[i] || bus.RspReady[i]);
        if (!Reset_n)               return 2'b00;
        if (m_lock_owner == 0)      return {1'b0, elig[0]};
        if (m_lock_owner == 1)      return {elig[1], 1'b0};
        if (elig == 2'b11)          return m_rr_last ? 2'b01 : 2'b10;
        return elig;
    endfunction

    function automatic logic [12:0] port_result(input int p);
        if (p == 0)
            return alu_fn(bus.ReqA[7:0], bus.ReqB[7:0], bus.ReqOP[2:0], bus.ReqCond[2:0], bus.ReqSC[0]);
        return alu_fn(bus.ReqA[15:8], bus.ReqB[15:8], bus.ReqOP[5:3], bus.ReqCond[5:3], bus.ReqSC[1]);
    endfunction

    task automatic model_edge(input logic [1:0] g);
        if (!Reset_n) begin
            m_valid      = 2'b00;
            m_rr_last    = 1'b1;
            m_lock_owner = -1;
            m_lock_run   = 0;
            exp_q0.delete();
            exp_q1.delete();
            return;
        end
        if (m_valid[0] && bus.RspReady[0]) begin void'(exp_q0.pop_front()); m_valid[0] = 1'b0; end
        if (m_valid[1] && bus.RspReady[1]) begin void'(exp_q1.pop_front()); m_valid[1] = 1'b0; end
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                if (p == 0) exp_q0.push_back(port_result(0));
                else        exp_q1.push_back(port_result(1));
                m_valid[p] = 1'b1;
                m_rr_last  = (p == 1);
                // A lock run counts grants; the grant that reaches LOCK_MAX ends it.
                if (m_lock_owner < 0) begin
                    if (bus.ReqLock[p] && LOCK_MAX > 1) begin
                        m_lock_owner = p;
                        m_lock_run   = 1;
                    end
                end else begin
                    m_lock_run++;
                    if (!bus.ReqLock[p] || m_lock_run >= LOCK_MAX) begin
                        m_lock_owner = -1;
                        m_lock_run   = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: check combinational outputs for the current inputs, clock, check registered outputs.
    task automatic step();
        logic [1:0]  g;
        logic [22:0] exp_drv;
        #1;
        g = model_grant();
        obs_grant = bus.ReqReady;
        chk("req_ready", 32'(bus.ReqReady), 32'(g));
        if (g == 2'b01)
            exp_drv = {bus.ReqA[7:0], bus.ReqB[7:0], bus.ReqOP[2:0], bus.ReqCond[2:0], bus.ReqSC[0]};
        else if (g == 2'b10)
            exp_drv = {bus.ReqA[15:8], bus.ReqB[15:8], bus.ReqOP[5:3], bus.ReqCond[5:3], bus.ReqSC[1]};
        else
            exp_drv = {8'd0, 8'd0, 3'd0, 3'b111, 1'b0};
        chk("alu_drive", 32'({bus.AluInputA, bus.AluInputB, bus.AluOP, bus.AluCondition, bus.AluSC_in}),
            32'(exp_drv));
        @(posedge Clk);
        model_edge(g);
        #1;
        chk("rsp_valid", 32'(bus.RspValid), 32'(m_valid));
        if (m_valid[0] && exp_q0.size() > 0)
            chk("rsp0_data", 32'({bus.RspFlags[4:0], bus.RspOut[7:0]}), 32'(exp_q0[0]));
        if (m_valid[1] && exp_q1.size() > 0)
            chk("rsp1_data", 32'({bus.RspFlags[9:5], bus.RspOut[15:8]}), 32'(exp_q1[0]));
    endtask

    task automatic set_port(input int p, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic [2:0] cond, input logic sc);
        if (p == 0) begin
            bus.ReqA[7:0] = a; bus.ReqB[7:0] = b; bus.ReqOP[2:0] = op;
            bus.ReqCond[2:0] = cond; bus.ReqSC[0] = sc;
        end else begin
            bus.ReqA[15:8] = a; bus.ReqB[15:8] = b; bus.ReqOP[5:3] = op;
            bus.ReqCond[5:3] = cond; bus.ReqSC[1] = sc;
        end
    endtask

    task automatic rand_ops();
        bus.ReqA    = 16'($urandom);
        bus.ReqB    = 16'($urandom);
        bus.ReqOP   = 6'($urandom);
        bus.ReqCond = 6'($urandom);
        bus.ReqSC   = 2'($urandom);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int         port;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [2:0] cond;
        logic       sc;
        logic [7:0] exp_out;
        logic [4:0] exp_flags;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] seq[6];
    logic [1:0] exp_seq[6];
    logic [7:0] held;

    initial begin
        // flags: {cond_flag, sc_out, odd, parity, zero}
        vecs[0] = '{0, 8'hF0, 8'h20, 3'd0, 3'b111, 1'b0, 8'h10, 5'b01010}; // KADD with carry out
        vecs[1] = '{1, 8'h05, 8'h03, 3'd0, 3'b010, 1'b0, 8'h08, 5'b10010}; // A>B condition true
        vecs[2] = '{1, 8'h05, 8'h03, 3'd0, 3'b111, 1'b0, 8'h08, 5'b00010}; // never-condition
        vecs[3] = '{0, 8'h05, 8'h05, 3'd1, 3'b000, 1'b0, 8'h00, 5'b10001}; // zero result, equal
        vecs[4] = '{1, 8'hFF, 8'h0F, 3'd2, 3'b111, 1'b0, 8'h0F, 5'b00100}; // AND, even parity
        vecs[5] = '{0, 8'h81, 8'h00, 3'd5, 3'b111, 1'b1, 8'h03, 5'b01100}; // shift-left with SC_in

        m_valid = 2'b00; m_rr_last = 1'b1; m_lock_owner = -1; m_lock_run = 0;
        bus.ReqLock = 2'b00; bus.RspReady = 2'b00;
        rand_ops();

        // Reset held two cycles with both requesters valid
        bus.ReqValid = 2'b11;
        Reset_n = 1'b0;
        step();
        chk("rst_ready_c1", 32'(obs_grant), 32'd0);
        step();
        chk("rst_ready_c2", 32'(obs_grant), 32'd0);
        chk("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
        chk("rst_rsp_out", 32'(bus.RspOut), 32'd0);
        chk("rst_rsp_flags", 32'(bus.RspFlags), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        Reset_n = 1'b1;
        step();
        chk("post_rst_grant", 32'(obs_grant), 32'b01);

        // Table vectors, one requester at a time
        do_reset();
        bus.RspReady = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            set_port(vecs[k].port, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].cond, vecs[k].sc);
            bus.ReqValid = (vecs[k].port == 0) ? 2'b01 : 2'b10;
            step();
            chk("vec_valid", 32'(bus.RspValid), 32'(bus.ReqValid));
            if (vecs[k].port == 0) begin
                chk("vec_out", 32'(bus.RspOut[7:0]), 32'(vecs[k].exp_out));
                chk("vec_flags", 32'(bus.RspFlags[4:0]), 32'(vecs[k].exp_flags));
            end else begin
                chk("vec_out", 32'(bus.RspOut[15:8]), 32'(vecs[k].exp_out));
                chk("vec_flags", 32'(bus.RspFlags[9:5]), 32'(vecs[k].exp_flags));
            end
        end

        // Contention: strict alternation starting at port 0
        do_reset();
        bus.ReqValid = 2'b11; bus.RspReady = 2'b11; bus.ReqLock = 2'b00;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
            seq[k] = obs_grant;
        end
        for (int k = 0; k < 6; k++) chk("contention_grant", 32'(seq[k]), 32'(exp_seq[k]));

        // Backpressure on port 1: its full slot blocks it, port 0 streams
        bus.RspReady = 2'b01;
        held = bus.RspOut[15:8];
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            step();
            chk("bp_grant", 32'(obs_grant), 32'b01);
            chk("bp_hold", 32'(bus.RspOut[15:8]), 32'(held));
        end
        bus.RspReady = 2'b11;
        rand_ops();
        step();
        chk("bp_release_grant", 32'(obs_grant), 32'b10);

        // Lock with watchdog: port 1 keeps ReqLock high
        do_reset();
        bus.RspReady = 2'b11; bus.ReqLock = 2'b10;
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 6; k++) begin
            bus.ReqValid = (k == 0) ? 2'b10 : 2'b11;
            rand_ops();
            step();
            seq[k] = obs_grant;
        end
        for (int k = 0; k < 6; k++) chk("lock_grant", 32'(seq[k]), 32'(exp_seq[k]));

        // Reset in the middle of a locked run
        do_reset();
        bus.RspReady = 2'b00; bus.ReqLock = 2'b10;
        bus.ReqValid = 2'b10; rand_ops(); step();
        bus.RspReady = 2'b11;
        bus.ReqValid = 2'b11; rand_ops(); step();
        chk("midlock_state", 32'(dbg_state), 32'd2);
        Reset_n = 1'b0;
        step();
        chk("midlock_rst_ready", 32'(obs_grant), 32'd0);
        chk("midlock_rsp_valid", 32'(bus.RspValid), 32'd0);
        chk("midlock_idle", 32'(dbg_state), 32'd0);
        Reset_n = 1'b1;
        bus.ReqLock = 2'b00;
        step();
        chk("midlock_first_grant", 32'(obs_grant), 32'b01);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bus.ReqValid = 2'($urandom_range(0, 3));
            bus.RspReady = 2'($urandom_range(0, 3));
            bus.ReqLock  = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            Reset_n      = ($urandom_range(0, 60) != 0);
            rand_ops();
            step();
        end
        Reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters, e.g. the execute stage (port 0) and the branch-compare path (port 1).
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers each result and its status flags into a per-requester response slot.
- An optional lock lets one requester issue back-to-back dependent ops without interleaving; a watchdog bounds the lock.

Parameters:
- W, 8, datapath width; must match the ALU's W.
- LOCK_MAX, 4, maximum consecutive locked grants before a forced release (at least 1).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  synchronous active-low reset.
- ReqValid  in  2  per-requester request valid.
- ReqReady  out  2  per-requester grant; the handshake completes when ReqValid[i] and ReqReady[i] are both high.
- ReqA  in  2*W  operand A; requester i uses [i*W +: W].
- ReqB  in  2*W  operand B, same packing.
- ReqOP  in  6  ALU opcode per requester, [i*3 +: 3].
- ReqCond  in  6  condition code per requester, [i*3 +: 3].
- ReqSC  in  2  shift/carry-in per requester.
- ReqLock  in  2  1 = keep the grant after this op.
- RspValid  out  2  response held in requester i's slot.
- RspReady  in  2  requester accepts its response.
- RspOut  out  2*W  registered ALU result per requester.
- RspFlags  out  10  per requester, [i*5 +: 5] = {condition_flag, SC_out, Odd, Parity, Zero}.
- AluInputA  out  W  to ALU InputA.
- AluInputB  out  W  to ALU InputB.
- AluOP  out  3  to ALU OP.
- AluCondition  out  3  to ALU Condition.
- AluSC_in  out  1  to ALU SC_in.
- AluOut  in  W  from ALU Out.
- AluZero, AluParity, AluOdd, AluSC_out, AluCondFlag  in  1 each  from the ALU.

Behaviour:
- Reset (Reset_n=0 at a clock edge):
  - RspValid=00, RspOut=0, RspFlags=0.
  - State=IDLE, rr_last=1 (so port 0 wins the first tie), lock_cnt=0.
  - ReqReady is 00 while Reset_n=0.
- Slot free for port i: free[i] = !RspValid[i] || RspReady[i].
- Eligibility: elig[i] = ReqValid[i] && free[i].
- Grant is combinational, at most one bit per cycle:
  - IDLE: if both are eligible, grant the port != rr_last; otherwise grant whichever one is eligible.
  - LOCK_i: grant only port i, when elig[i]; the other port gets ReqReady=0 even if eligible.
- ALU drive:
  - On a grant, AluInputA/B, AluOP, AluCondition and AluSC_in come combinationally from the granted port.
  - With no grant, drive all of them 0, except AluCondition=3'b111 (no-op).
- Capture, at the edge of a handshake on port i:
  - RspOut[i] <= AluOut; RspFlags[i] <= the ALU flags; RspValid[i] <= 1; rr_last <= i.
- Latency and throughput:
  - Latency is one cycle: the response is visible the cycle after the handshake.
  - Throughput is one op per cycle in aggregate.
- Response clear: if RspReady[i] && RspValid[i] with no new handshake on port i, RspValid[i] <= 0.
  - A pop and a new capture in the same cycle leave RspValid=1 and replace the data.
  - RspOut/RspFlags hold stable while RspValid=1 and RspReady=0.
- FSM, evaluated on a handshake on port i:
  - IDLE -> LOCK_i if ReqLock[i]=1 and LOCK_MAX>1; lock_cnt <= 1.
  - LOCK_i, ReqLock[i]=1 and lock_cnt<LOCK_MAX-1: stay; lock_cnt++.
  - LOCK_i, ReqLock[i]=0 or lock_cnt==LOCK_MAX-1: go to IDLE; lock_cnt <= 0. This is the watchdog release, so at most LOCK_MAX consecutive locked grants.
  - No handshake: state holds, including in LOCK_i while port i is stalled by backpressure or has ReqValid=0.
- Simultaneous events:
  - A reset in any state overrides a handshake in the same cycle.
  - A reset mid-lock returns to IDLE and drops pending responses.
- Arithmetic, widths and flags are those of the ALU; the block never alters a result.

Test Plan:
- Reset: Reset_n=0 for 2 cycles with ReqValid=11 -> ReqReady=00, RspValid=00. At the first cycle after release, ReqReady=01.
- Single op: port 0 issues KADD, A=8'hF0, B=8'h20 -> the next cycle has RspValid=01, RspOut[0]=8'h10, SC_out=1, Zero=0.
- Condition: port 1, Cond=3'b010, A=5, B=3 -> condition_flag[1]=1. Then Cond=3'b111 -> 0.
- Contention: ReqValid=11 and RspReady=11 held for 6 cycles -> grants go 0,1,0,1,0,1, one per cycle, with no lost responses.
- Backpressure: RspValid[1]=1, RspReady[1]=0, ReqValid=11 -> port 1 is never granted, port 0 is granted every cycle, and RspOut[1] stays unchanged. Raising RspReady[1] grants port 1 in that same cycle.
- Lock and watchdog (LOCK_MAX=4): port 1 holds ReqLock=1 for 6 ops while port 0 is valid -> port 1 gets 4 consecutive grants, then port 0 is granted. Repeat the run with Reset_n pulsed low after 2 locked ops -> the FSM is IDLE, RspValid=00, and port 0 is granted first after release.
